// File: rtl/ps2_keymap_receiver.sv
// Receive-only PS/2 decoder: synchronise and glitch-filter the pins, deframe bytes, decode
// scan-code prefixes into key events and keep a held-key bitmap from a parameter lookup table.
module ps2_keymap_receiver #(
  parameter int                    NUM_KEYS    = 32,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = (NUM_KEYS*9)'(18'h2D615),
  parameter int                    SCAN_SET    = 2,
  parameter int                    FILTER_LEN  = 8,
  parameter int                    TIMEOUT_CYC = 100000,
  parameter int                    ERR_W       = 8,
  localparam int                   IDX_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ps2_clk,
  input  logic                i_ps2_dat,
  input  logic                i_clear,
  output logic [NUM_KEYS-1:0] o_keys,
  output logic                o_evt_valid,
  output logic [7:0]          o_evt_code,
  output logic                o_evt_ext,
  output logic                o_evt_brk,
  output logic                o_evt_hit,
  output logic [IDX_W-1:0]    o_evt_idx,
  output logic                o_frame_err,
  output logic [ERR_W-1:0]    o_err_cnt,
  output logic [1:0]          o_dbg_state
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]          clk_sync_q, dat_sync_q;
  logic                clk_s, dat_s;
  logic                filt_q, filt_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                fall;
  state_t              state_q, state_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                err_d;
  logic                bv_q, bv_d;
  logic [7:0]          byte_q, byte_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic                ev_d, ev_ext, ev_brk;
  logic [7:0]          ev_code;
  logic                hit;
  logic [IDX_W-1:0]    idx;
  logic                ignore_byte;
  logic [NUM_KEYS-1:0] keys_q, keys_d;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // The filtered clock only follows the pin after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmr_d    = (state_q == S_IDLE) ? '0 : tmr_q + 1'b1;
    err_d    = 1'b0;
    bv_d     = 1'b0;
    byte_d   = byte_q;
    if (fall) begin
      tmr_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_s) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (dat_s && (^{shift_q, par_q})) begin
            bv_d   = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != S_IDLE && tmr_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      tmr_d   = '0;
    end
  end

  // Device responses and the pause prefix carry no key meaning.
  always_comb begin
    case (byte_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF, 8'hE1: ignore_byte = 1'b1;
      default:                                                ignore_byte = 1'b0;
    endcase
  end

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    ev_d    = 1'b0;
    ev_ext  = ext_q;
    ev_brk  = (SCAN_SET == 1) ? byte_q[7] : brk_q;
    ev_code = (SCAN_SET == 1) ? {1'b0, byte_q[6:0]} : byte_q;
    if (bv_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (SCAN_SET == 2 && byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (ignore_byte) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        ev_d  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (i_clear) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // Descending scan so the lowest matching index wins; all-zero entries are unused slots.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] != 9'h000 && KEY_CODES[9*i +: 9] == {ev_ext, ev_code}) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    keys_d = keys_q;
    if (ev_d && hit) keys_d[idx] = ~ev_brk;
    if (i_clear)     keys_d = '0;
  end

  // o_evt_valid is a one-cycle strobe with no ready; the other o_evt_* fields hold until the next event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmr_q       <= '0;
      bv_q        <= 1'b0;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      keys_q      <= '0;
      o_evt_valid <= 1'b0;
      o_evt_code  <= '0;
      o_evt_ext   <= 1'b0;
      o_evt_brk   <= 1'b0;
      o_evt_hit   <= 1'b0;
      o_evt_idx   <= '0;
      o_frame_err <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], i_ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], i_ps2_dat};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmr_q       <= tmr_d;
      bv_q        <= bv_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      keys_q      <= keys_d;
      o_evt_valid <= ev_d;
      if (ev_d) begin
        o_evt_code <= ev_code;
        o_evt_ext  <= ev_ext;
        o_evt_brk  <= ev_brk;
        o_evt_hit  <= hit;
        o_evt_idx  <= idx;
      end
      o_frame_err <= err_d;
      if (o_frame_err && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

  assign o_keys      = keys_q;
  assign o_dbg_state = state_q;

endmodule
